// File: rtl/mult_arb_pkg.sv
// Shared state type and defaults for the mult32 sharing controller.
// Arbitration policy is selected in rr_arb2 (MULT_ARB_FIXED_PRIO_EN).
package mult_arb_pkg;

    localparam int unsigned NUM_REQ          = 2;
    localparam int unsigned MULT_LAT_DEFAULT = 66;
    localparam int unsigned W_DEFAULT        = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } mult_arb_state_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester grant. Round-robin by default; defining
// MULT_ARB_FIXED_PRIO_EN gives requester 0 fixed priority and drops last_grant.
module rr_arb2
    import mult_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req_valid,
`ifndef MULT_ARB_FIXED_PRIO_EN
    input  logic               i_last_grant,
`endif
    output logic [NUM_REQ-1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        case (i_req_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
`ifdef MULT_ARB_FIXED_PRIO_EN
            2'b11:   o_grant = 2'b01;
`else
            // On a conflict the requester that was not served last wins.
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
`endif
            default: o_grant = '0;
        endcase
    end

endmodule

// File: rtl/mult32_arbiter.sv
// Shares one sequential mult32 between two valid/ready requesters: latch operands,
// pulse the multiplier reset, wait MULT_LAT cycles, return the product. See rr_arb2 for MULT_ARB_FIXED_PRIO_EN.
module mult32_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT,
    parameter int unsigned W        = W_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [W-1:0]         i_req_a0,
    input  logic [W-1:0]         i_req_b0,
    input  logic [W-1:0]         i_req_a1,
    input  logic [W-1:0]         i_req_b1,
    output logic [NUM_REQ-1:0]   o_resp_valid,
    input  logic [NUM_REQ-1:0]   i_resp_ready,
    output logic [2*W-1:0]       o_resp_data,
    output logic                 o_busy,
    output logic                 o_mult_rst,
    output logic [W-1:0]         o_mult_a,
    output logic [W-1:0]         o_mult_b,
    input  logic [2*W-1:0]       i_mult_res
);

    localparam int unsigned CntW = $clog2(MULT_LAT + 1);

    mult_arb_state_t     r_state;
    logic [CntW-1:0]     r_cnt;
    logic                r_owner;
    logic [W-1:0]        r_mult_a;
    logic [W-1:0]        r_mult_b;
    logic [2*W-1:0]      r_resp_data;
    logic [NUM_REQ-1:0]  w_grant;
    logic [NUM_REQ-1:0]  w_resp_valid;
`ifndef MULT_ARB_FIXED_PRIO_EN
    logic                r_last_grant;
`endif

    rr_arb2 u_arb (
        .i_req_valid  (i_req_valid),
`ifndef MULT_ARB_FIXED_PRIO_EN
        .i_last_grant (r_last_grant),
`endif
        .o_grant      (w_grant)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_resp_data <= '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant != '0) begin
                        r_owner  <= w_grant[1];
                        r_mult_a <= w_grant[1] ? i_req_a1 : i_req_a0;
                        r_mult_b <= w_grant[1] ? i_req_b1 : i_req_b0;
                        r_state  <= StLoad;
                    end
                end
                StLoad: begin
                    r_cnt   <= CntW'(MULT_LAT);
                    r_state <= StRun;
                end
                StRun: begin
                    r_cnt <= r_cnt - CntW'(1);
                    // Count 1 marks the last RUN cycle, where mult_res is settled.
                    if (r_cnt == CntW'(1)) begin
                        r_resp_data <= i_mult_res;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (i_resp_ready[r_owner]) begin
`ifndef MULT_ARB_FIXED_PRIO_EN
                        r_last_grant <= r_owner;
`endif
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        w_resp_valid = '0;
        if (r_state == StDone && !i_rst) begin
            w_resp_valid = req_onehot(r_owner);
        end
    end

    assign o_req_ready  = (r_state == StIdle && !i_rst) ? w_grant : '0;
    assign o_resp_valid = w_resp_valid;
    assign o_resp_data  = r_resp_data;
    assign o_busy       = (r_state != StIdle);
    assign o_mult_rst   = i_rst | (r_state == StLoad);
    assign o_mult_a     = r_mult_a;
    assign o_mult_b     = r_mult_b;

endmodule
